io_switch_led_port: RTL and testbench

Memory-mapped IO responder on the board side of the CPU's memory/IO split. It accepts the LED chip select (write) and switch chip select (read) strobes together with the low address bits and the 16-bit IO write data. It drives the 24 board LEDs from registers and returns debounced, synchronized switch state on the 16-bit IO read bus. A sticky change flag lets software poll for switch activity.

---
 rtl/io_switch_led_port.sv | 95 +++++++++
 tb/tb_io_switch_led_port.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/io_switch_led_port.sv
// Memory-mapped LED/switch IO responder with debounced switches and a sticky change flag.
// Define IO_LED_READBACK_EN to make the LED registers readable at 0x60/0x62.
module io_switch_led_port #(
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        led_cs,
  input  logic        sw_cs,
  input  logic [7:0]  addr,
  input  logic [15:0] wdata,
  input  logic [23:0] sw,
  output logic [15:0] io_rdata,
  output logic [23:0] led
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [7:0] ADDR_LED_LO = 8'h60;
  localparam logic [7:0] ADDR_LED_HI = 8'h62;
  localparam logic [7:0] ADDR_SW_LO  = 8'h70;
  localparam logic [7:0] ADDR_SW_HI  = 8'h72;
  localparam logic [7:0] ADDR_CHG    = 8'h74;

  logic [23:0]      sync1, sync2, sample, deb, deb_next, stable;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic             chg;
  logic             chg_clr;
  logic             unused_wdata_hi;

  assign unused_wdata_hi = ^wdata[15:8];
  assign tick    = (tick_cnt == CNT_LAST);
  assign chg_clr = sw_cs && (addr == ADDR_CHG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= '0;
    end else if (led_cs) begin
      if (addr == ADDR_LED_LO) led[15:0]  <= wdata;
      if (addr == ADDR_LED_HI) led[23:16] <= wdata[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  // Each bit follows the synchronized input only once two consecutive tick samples agree.
  always_comb begin
    stable   = ~(sync2 ^ sample);
    deb_next = deb;
    if (tick) deb_next = (deb & ~stable) | (sync2 & stable);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      sample <= '0;
      deb    <= '0;
      chg    <= 1'b0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
      if (tick) sample <= sync2;
      deb <= deb_next;
      chg <= (deb_next != deb) | (chg & ~chg_clr);
    end
  end

  always_comb begin
    io_rdata = '0;
    if (sw_cs) begin
      case (addr)
`ifdef IO_LED_READBACK_EN
        ADDR_LED_LO: io_rdata = led[15:0];
        ADDR_LED_HI: io_rdata = {8'h00, led[23:16]};
`endif
        ADDR_SW_LO:  io_rdata = deb[15:0];
        ADDR_SW_HI:  io_rdata = {8'h00, deb[23:16]};
        ADDR_CHG:    io_rdata = {15'h0000, chg};
        default:     io_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_switch_led_port.sv
// Directed scoreboard bench for io_switch_led_port with a 4-cycle debounce tick.
module tb_io_switch_led_port;

  localparam int DEB = 4;

`ifdef IO_LED_READBACK_EN
  localparam logic [15:0] EXP_LED_LO_RD = 16'hA5A5;
  localparam logic [15:0] EXP_LED_HI_RD = 16'h00C3;
`else
  localparam logic [15:0] EXP_LED_LO_RD = 16'h0000;
  localparam logic [15:0] EXP_LED_HI_RD = 16'h0000;
`endif

  logic        clk;
  logic        rst_n;
  logic        led_cs;
  logic        sw_cs;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic [23:0] sw;
  logic [15:0] io_rdata;
  logic [23:0] led;

  int          checks;
  int          failures;
  int          edge_n;
  string       tag_q[$];
  logic [23:0] exp_q[$];

  io_switch_led_port #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .led_cs   (led_cs),
    .sw_cs    (sw_cs),
    .addr     (addr),
    .wdata    (wdata),
    .sw       (sw),
    .io_rdata (io_rdata),
    .led      (led)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edges since reset release; the debounce tick lands on every DEB-th edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input string tag, input logic [23:0] expected);
    tag_q.push_back(tag);
    exp_q.push_back(expected);
  endtask

  task automatic checkOutput(input logic [23:0] observed);
    string       tag;
    logic [23:0] expected;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("[TB] FAIL scoreboard_empty observed=%h expected=none", observed);
    end else begin
      tag      = tag_q.pop_front();
      expected = exp_q.pop_front();
      assert (observed === expected) else begin
        failures++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
    end
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [15:0] exp_val, input string tag);
    sw_cs = 1'b1;
    addr  = a;
    applyStimulus(tag, {8'h00, exp_val});
    #2;
    checkOutput({8'h00, io_rdata});
    @(posedge clk);
    #1;
    sw_cs = 1'b0;
    addr  = 8'h00;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [15:0] d);
    led_cs = 1'b1;
    addr   = a;
    wdata  = d;
    @(posedge clk);
    #1;
    led_cs = 1'b0;
    addr   = 8'h00;
    wdata  = 16'h0000;
  endtask

  task automatic check_led(input logic [23:0] exp_val, input string tag);
    applyStimulus(tag, exp_val);
    checkOutput(led);
  endtask

  // Leaves the bench just after an edge on which the debounce tick fired.
  task automatic wait_tick_edge();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2 * DEB; i++) begin
      @(posedge clk);
      #1;
      if (edge_n % DEB == 0) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      failures++;
      $display("[TB] FAIL tick_align observed=none expected=tick within %0d edges", 2 * DEB);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    led_cs   = 1'b0;
    sw_cs    = 1'b0;
    addr     = 8'h00;
    wdata    = 16'h0000;
    sw       = 24'hFFFFFF;

    repeat (3) @(posedge clk);
    #1;
    check_led(24'h000000, "reset_led");
    applyStimulus("reset_rdata_idle", 24'h000000);
    checkOutput({8'h00, io_rdata});
    bus_read(8'h70, 16'h0000, "reset_sw_lo");
    sw    = 24'h000000;
    rst_n = 1'b1;
    bus_read(8'h74, 16'h0000, "post_reset_chg");

    bus_write(8'h60, 16'hA5A5);
    check_led(24'h00A5A5, "led_write_lo");
    bus_write(8'h62, 16'h12C3);
    check_led(24'hC3A5A5, "led_write_hi");
    bus_read(8'h62, EXP_LED_HI_RD, "led_readback_hi");
    bus_read(8'h60, EXP_LED_LO_RD, "led_readback_lo");
    bus_write(8'h70, 16'hFFFF);
    bus_write(8'h64, 16'hFFFF);
    check_led(24'hC3A5A5, "led_ignore_other_offsets");
    bus_read(8'h66, 16'h0000, "unmapped_read");

    sw = 24'h0F00FF;
    repeat (12) @(posedge clk);
    #1;
    bus_read(8'h70, 16'h00FF, "settle_sw_lo");
    bus_read(8'h72, 16'h000F, "settle_sw_hi");
    bus_read(8'h74, 16'h0001, "settle_chg_set");
    bus_read(8'h74, 16'h0000, "settle_chg_cleared");

    sw = 24'h0F00FE;
    repeat (2) @(posedge clk);
    #1;
    sw = 24'h0F00FF;
    repeat (12) @(posedge clk);
    #1;
    bus_read(8'h70, 16'h00FF, "bounce_sw_lo");
    bus_read(8'h74, 16'h0000, "bounce_chg");

    // deb moves on the second tick after the change, i.e. 8 edges later.
    wait_tick_edge();
    sw = 24'h0F00F0;
    repeat (7) @(posedge clk);
    #1;
    bus_read(8'h74, 16'h0000, "collision_chg_before");
    bus_read(8'h74, 16'h0001, "collision_set_wins");
    bus_read(8'h70, 16'h00F0, "collision_sw_lo");
    bus_read(8'h74, 16'h0000, "collision_chg_cleared");

    wait_tick_edge();
    sw = 24'h123456;
    repeat (3) @(posedge clk);
    #1;
    bus_write(8'h60, 16'hFFFF);
    check_led(24'hC3FFFF, "midop_led_write");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_led(24'h000000, "midop_reset_led");
    applyStimulus("midop_reset_rdata_idle", 24'h000000);
    checkOutput({8'h00, io_rdata});
    bus_read(8'h70, 16'h0000, "midop_reset_sw_lo");
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    bus_read(8'h70, 16'h0000, "midop_no_stale_deb");
    bus_read(8'h74, 16'h0000, "midop_no_stale_chg");
    repeat (6) @(posedge clk);
    #1;
    bus_read(8'h70, 16'h3456, "midop_resettle_lo");
    bus_read(8'h72, 16'h0012, "midop_resettle_hi");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
